// File: rtl/prequant_pkg.sv
// Shared types and helpers for the streaming pre-quantiser.
package prequant_pkg;
  localparam int BLOCK_COEFS = 64;

  typedef enum logic {
    RND_TRUNC     = 1'b0,
    RND_HALF_AWAY = 1'b1
  } round_mode_e;

  typedef logic [BLOCK_COEFS-1:0][31:0] qmat_t;

  // Clamp a signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/prequant_qscale_stream_div_lane.sv
// One quantiser lane: forms num/den, divides with the chosen rounding,
// saturates, and carries the result plus zero-divisor flag down the pipe.
module prequant_div_lane
  import prequant_pkg::*;
#(
  parameter int DW          = 16,
  parameter int PIPE_STAGES = 2,
  parameter int ROUND_MODE  = 0
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          en,
  input  logic [DW-1:0] coef,
  input  logic [31:0]   qscale,
  input  logic [31:0]   qmat,
  output logic [DW-1:0] q,
  output logic          zero
);
  logic signed [DW+1:0] num;
  logic signed [31:0]   den;
  logic signed [33:0]   n_w, d_w, n_abs, d_abs, quo;
  logic [DW-1:0]        q_c;
  logic                 z_c;
  logic [PIPE_STAGES:0][DW-1:0] q_pipe;
  logic [PIPE_STAGES:0]         z_pipe;

  assign num = {coef, 2'b00};
  assign den = $signed(qscale) * $signed(qmat);
  assign z_c = (den == 32'sd0);

  // 34 bits holds |den| for den = -2^31 and any shifted coefficient.
  always_comb begin
    n_w   = 34'(num);
    d_w   = z_c ? 34'sd1 : 34'(den);
    n_abs = n_w[33] ? -n_w : n_w;
    d_abs = d_w[33] ? -d_w : d_w;
    if (ROUND_MODE == int'(RND_HALF_AWAY)) begin
      quo = (n_abs + (d_abs >>> 1)) / d_abs;
      if (n_w[33] != d_w[33]) quo = -quo;
    end else begin
      quo = n_w / d_w;
    end
    if (z_c) quo = '0;
  end

  assign q_c = DW'(sat_dw(64'(quo), DW));

  // The divide above is left for retiming across these result registers.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      q_pipe <= '0;
      z_pipe <= '0;
    end else if (en) begin
      q_pipe[0] <= q_c;
      z_pipe[0] <= z_c;
      for (int i = 1; i <= PIPE_STAGES; i++) begin
        q_pipe[i] <= q_pipe[i-1];
        z_pipe[i] <= z_pipe[i-1];
      end
    end
  end

  assign q    = q_pipe[PIPE_STAGES];
  assign zero = z_pipe[PIPE_STAGES];
endmodule

// File: rtl/prequant_qscale_stream.sv
// Streaming pre-quantiser: (coef << 2) / (QSCALE * QMAT[pos]) over LANES
// coefficients per beat, with block framing and whole-pipe backpressure.
module prequant_qscale_stream
  import prequant_pkg::*;
#(
  parameter int DW          = 16,
  parameter int LANES       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int ROUND_MODE  = 0
) (
  input  logic                               CLOCK,
  input  logic                               RESET,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_first,
  input  logic [LANES-1:0][DW-1:0]           in_data,
  input  logic [31:0]                        QSCALE,
  input  logic                               is_y,
  input  logic [BLOCK_COEFS-1:0][31:0]       Y_QMAT,
  input  logic [BLOCK_COEFS-1:0][31:0]       C_QMAT,
  input  logic                               err_clear,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES-1:0][DW-1:0]           out_data,
  output logic                               out_first,
  output logic                               out_last,
  output logic                               qscale_err
);
  localparam logic [5:0] STEP     = 6'(LANES % BLOCK_COEFS);
  localparam logic [5:0] LAST_POS = 6'(BLOCK_COEFS - LANES);

  logic                 en, acc, blk_start;
  logic [5:0]           pos, pos_eff;
  logic [31:0]          qscale_lat, qscale_eff;
  logic                 is_y_lat, is_y_eff;
  qmat_t                qmat;
  logic [PIPE_STAGES:0] vld_pipe, first_pipe, last_pipe;
  logic [LANES-1:0]     lane_zero;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign acc       = in_valid && en;
  assign pos_eff   = in_first ? 6'd0 : pos;
  assign blk_start = (pos_eff == 6'd0);
  // The block-start beat itself must already see the new block parameters.
  assign qscale_eff = blk_start ? QSCALE : qscale_lat;
  assign is_y_eff   = blk_start ? is_y : is_y_lat;
  assign qmat       = is_y_eff ? Y_QMAT : C_QMAT;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      pos        <= '0;
      qscale_lat <= '0;
      is_y_lat   <= 1'b0;
    end else if (acc) begin
      pos <= pos_eff + STEP;
      if (blk_start) begin
        qscale_lat <= QSCALE;
        is_y_lat   <= is_y;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else if (en) begin
      vld_pipe[0]   <= acc;
      first_pipe[0] <= acc && blk_start;
      last_pipe[0]  <= acc && (pos_eff == LAST_POS);
      for (int i = 1; i <= PIPE_STAGES; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[PIPE_STAGES];
  assign out_first = first_pipe[PIPE_STAGES];
  assign out_last  = last_pipe[PIPE_STAGES];

  // Bubbles may carry a zero flag from idle inputs, so only valid beats count.
  always_ff @(posedge CLOCK) begin
    if (!RESET)                      qscale_err <= 1'b0;
    else if (out_valid && |lane_zero) qscale_err <= 1'b1;
    else if (err_clear)              qscale_err <= 1'b0;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    prequant_div_lane #(
      .DW(DW), .PIPE_STAGES(PIPE_STAGES), .ROUND_MODE(ROUND_MODE)
    ) u_lane (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .en    (en),
      .coef  (in_data[l]),
      .qscale(qscale_eff),
      .qmat  (qmat[pos_eff + 6'(l)]),
      .q     (out_data[l]),
      .zero  (lane_zero[l])
    );
  end
endmodule
